// File: rtl/bus_packer_pkg.sv
// bus_packer_pkg: shared width helpers for the bus packer/unpacker family
package bus_packer_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int out_w(input int in_w, input int beats);
    return in_w * beats;
  endfunction
endpackage

// File: rtl/bus_out_reg.sv
// bus_out_reg: registered data+count output stage with valid/ready handshake
// Ports: load_i/data_i/count_i capture a new word; ready_i drains it;
//        data_o/count_o/valid_o are the registered word and its qualifier.
module bus_out_reg #(
  parameter int DW = 8,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [CW-1:0] count_i,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] count_o,
  output logic          valid_o
);
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  always_comb begin
    valid_d = load_i || (valid_q && !ready_i);
    data_d  = load_i ? data_i : data_q;
    count_d = load_i ? count_i : count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  assign data_o  = data_q;
  assign count_o = count_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/bus_packer.sv
// bus_packer: gathers BEATS narrow beats into one wide word with valid/ready on both sides
// Ports: in_data/in_valid/in_last/in_ready form the narrow input stream;
//        out_data/out_count/out_valid/out_ready form the packed output stream.
module bus_packer
  import bus_packer_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int BEATS     = 2,
  parameter bit LSB_FIRST = 1'b1,
  localparam int OUT_W    = out_w(IN_W, BEATS),
  localparam int CW       = clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [OUT_W-1:0] acc_q, acc_d, merged;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             in_fire, done;
  int               slot;
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign done     = in_fire && (cnt_q == CW'(BEATS - 1) || in_last);
  assign cnt_inc  = cnt_q + CW'(1);
  // slot index for the current beat; beat 0 lands in the top slot when MSB-first
  assign slot     = LSB_FIRST ? int'(cnt_q) : BEATS - 1 - int'(cnt_q);
  assign merged   = acc_q | (OUT_W'(in_data) << (slot * IN_W));
  always_comb begin
    acc_d = !in_fire ? acc_q : done ? '0 : merged;
    cnt_d = !in_fire ? cnt_q : done ? '0 : cnt_inc;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  bus_out_reg #(.DW(OUT_W), .CW(CW)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (done),
    .data_i  (merged),
    .count_i (cnt_inc),
    .ready_i (out_ready),
    .data_o  (out_data),
    .count_o (out_count),
    .valid_o (out_valid)
  );
endmodule

// File: tb/tb_bus_packer.sv
// tb_bus_packer: vector table, corner sequences and randomized model check for bus_packer
module tb_bus_packer;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_last, out_ready;
  logic [3:0] in_data;
  logic rdy, ov, m_rdy, m_ov, t_rdy, t_ov;
  logic [7:0] od, m_od;
  logic [11:0] t_od;
  logic [1:0] oc, m_oc, t_oc;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  bus_packer #(.IN_W(4), .BEATS(2), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy), .out_data(od), .out_count(oc), .out_valid(ov), .out_ready(out_ready));
  bus_packer #(.IN_W(4), .BEATS(2), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(m_rdy), .out_data(m_od), .out_count(m_oc), .out_valid(m_ov), .out_ready(out_ready));
  bus_packer #(.IN_W(4), .BEATS(3), .LSB_FIRST(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(t_rdy), .out_data(t_od), .out_count(t_oc), .out_valid(t_ov), .out_ready(out_ready));

  typedef struct {
    logic v, l, r;
    logic [3:0] d;
    logic rdy, ov;
    logic [7:0] dat, msb;
    logic [1:0] cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic l, logic r, logic [3:0] d, logic rdy_e, logic ov_e,
                              logic [7:0] dat = 8'h0, logic [7:0] msb = 8'h0, logic [1:0] cnt = 2'd0);
    vec_t x;
    x.v = v; x.l = l; x.r = r; x.d = d; x.rdy = rdy_e; x.ov = ov_e;
    x.dat = dat; x.msb = msb; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic r, input logic [3:0] d);
    in_valid = v; in_last = l; out_ready = r; in_data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pend[$];
  logic mv;
  logic [7:0] mw;
  logic [1:0] mc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = 4'hF; out_ready = 1'b0;
    #1;
    chk("reset_in_ready", 32'(rdy), 32'd0);
    repeat (2) begin
      tick();
      chk("reset_in_ready", 32'(rdy), 32'd0);
      chk("reset_out_valid", 32'(ov), 32'd0);
      chk("reset_out_data", 32'(od), 32'h00);
      chk("reset_out_count", 32'(oc), 32'd0);
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 4'h5);
    chk("post_reset_in_ready", 32'(rdy), 32'd1);
    tick();
    chk("post_reset_valid", 32'(ov), 32'd1);
    chk("post_reset_data", 32'(od), 32'h05);
    chk("post_reset_count", 32'(oc), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    chk("post_reset_drain", 32'(ov), 32'd0);

    tbl.push_back(mk(1, 0, 1, 4'h1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h8, 1, 1, 8'h81, 8'h18, 2'd2));
    tbl.push_back(mk(0, 0, 1, 4'h0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'h1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'h8, 1, 1, 8'h81, 8'h18, 2'd2));
    repeat (5) tbl.push_back(mk(1, 0, 0, 4'h2, 0, 1, 8'h81, 8'h18, 2'd2));
    tbl.push_back(mk(1, 0, 1, 4'h2, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h4, 1, 1, 8'h42, 8'h24, 2'd2));
    tbl.push_back(mk(0, 0, 1, 4'h0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h2, 1, 1, 8'h21, 8'h12, 2'd2));
    tbl.push_back(mk(1, 0, 1, 4'h3, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h4, 1, 1, 8'h43, 8'h34, 2'd2));
    tbl.push_back(mk(1, 0, 1, 4'h5, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h6, 1, 1, 8'h65, 8'h56, 2'd2));
    tbl.push_back(mk(0, 1, 1, 4'hF, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h2, 1, 1, 8'h21, 8'h12, 2'd2));
    tbl.push_back(mk(1, 0, 1, 4'h3, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'h4, 1, 1, 8'h43, 8'h34, 2'd2));
    tbl.push_back(mk(1, 1, 1, 4'h3, 1, 1, 8'h03, 8'h30, 2'd1));
    tbl.push_back(mk(0, 0, 1, 4'h0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d_in_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(ov), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_msb_valid", i), 32'(m_ov), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("vec%0d_out_data", i), 32'(od), 32'(tbl[i].dat));
        chk($sformatf("vec%0d_msb_data", i), 32'(m_od), 32'(tbl[i].msb));
        chk($sformatf("vec%0d_out_count", i), 32'(oc), 32'(tbl[i].cnt));
      end
    end

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 4'h7);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 4'h1);
    tick();
    chk("b3_after_1_valid", 32'(t_ov), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 4'h2);
    tick();
    chk("b3_after_2_valid", 32'(t_ov), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 4'h3);
    tick();
    chk("b3_word_valid", 32'(t_ov), 32'd1);
    chk("b3_word_data", 32'(t_od), 32'h321);
    chk("b3_word_count", 32'(t_oc), 32'd3);
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick();

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mv = 1'b0; mw = 8'h0; mc = 2'd0;
    pend.delete();
    for (int c = 0; c < 600; c++) begin
      logic v, l, r, fire;
      logic [3:0] d;
      v = ($urandom_range(3) != 0);
      l = ($urandom_range(4) == 0);
      r = ($urandom_range(2) != 0);
      d = 4'($urandom);
      drive(v, l, r, d);
      chk("rand_in_ready", 32'(rdy), 32'(!mv || r));
      fire = v && (!mv || r);
      if (mv && r) mv = 1'b0;
      if (fire) begin
        pend.push_back(d);
        if (pend.size() == 2 || l) begin
          mw = 8'h0;
          foreach (pend[k]) mw = mw | (8'(pend[k]) << (4 * k));
          mc = 2'(pend.size());
          mv = 1'b1;
          pend.delete();
        end
      end
      tick();
      chk("rand_out_valid", 32'(ov), 32'(mv));
      if (mv) begin
        chk("rand_out_data", 32'(od), 32'(mw));
        chk("rand_out_count", 32'(oc), 32'(mc));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
